monitor_bus_arbiter: RTL and testbench
======================================

Name: monitor_bus_arbiter

Overview:
Shares the monitor's 64 KiB bus (RAM/ROM, CPU state, history, monitor ctrl decode) between two requesters: the monitor CPU and a host debug bridge (UART/JTAG side). The CPU is the default owner. The host steals idle CPU cycles, or forces a one-cycle CPU stall after a bounded wait. The block sits between both requesters and the monitor bus decoder, and respects that decoder's one-cycle registered read latency.

Parameters:
HOST_MAX_WAIT, 15, cycles a pending host request may be refused before the CPU is stalled; 0 = host has absolute priority.
WAIT_W, 4, width of the wait counter; must hold HOST_MAX_WAIT.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_valid  in  1  CPU presents an access this cycle
cpu_address  in  16  CPU address
cpu_write  in  1  CPU write strobe
cpu_wdata  in  8  CPU write data
cpu_rdy  out  1  0 = CPU access not taken this cycle; CPU holds address/write/wdata
cpu_rdata  out  8  CPU read data
host_req  in  1  host request, level
host_address  in  16  host address
host_write  in  1  host write
host_wdata  in  8  host write data
host_ack  out  1  one-cycle pulse: host access done, host_rdata valid
host_rdata  out  8  host read data
bus_address  out  16  to monitor bus decoder
bus_write  out  1  to monitor bus decoder
bus_wdata  out  8  to RAM/ctrl write port
bus_rdata  in  8  decoder read mux; valid the cycle after the address cycle
grant_host  out  1  host owns the bus this cycle (debug)
stat_forced  out  16  forced-stall count (optional feature)

Behaviour:
- State registers: host_ack_q, wait_cnt[WAIT_W-1:0], cpu_pend, cpu_rdata_q, host_rdata_q, stat counter. All clear to 0 on reset.
- Reset outputs: grant_host=0, cpu_rdy=1, host_ack=0, cpu_rdata=0, host_rdata=0, bus_write=0, stat_forced=0. grant_host is forced to 0 while reset is high.
- grant_host (combinational) = host_req & ~host_ack_q & (~cpu_valid | wait_cnt==HOST_MAX_WAIT).
- cpu_rdy = ~grant_host.
- Bus mux: when grant_host=1, bus_* = host_*; otherwise bus_address=cpu_address, bus_wdata=cpu_wdata, bus_write=cpu_write & cpu_valid.
- host_ack_q <= grant_host. host_ack = host_ack_q.
  - No grant is possible in the ack cycle, so the host gets at most one access per 2 cycles, and the CPU always gets the cycle after a host access.
  - If host_req is still high after the ack cycle, that is a new request.
- wait_cnt:
  - cleared when grant_host=1 or host_req=0;
  - else increments when cpu_valid=1 and host_ack_q=0, saturating at HOST_MAX_WAIT.
- Read data path:
  - cpu_pend <= cpu_valid & ~grant_host.
  - cpu_rdata = cpu_pend ? bus_rdata : cpu_rdata_q. cpu_rdata_q loads bus_rdata when cpu_pend=1.
  - host_rdata = host_ack_q ? bus_rdata : host_rdata_q. host_rdata_q loads bus_rdata when host_ack_q=1.
  - Each requester therefore sees its own data, never the other's.
- Writes are single-cycle in the grant cycle. A write issues a host_ack with host_rdata undefined.
- Reset mid-access: the pending ack is dropped and read data is cleared. The host must re-request.
- Simultaneous events: host_req rising with an idle CPU is granted the same cycle. A CPU valid in the forced-grant cycle is stalled exactly 1 cycle.

Optional Feature:
MONITOR_ARB_STATS_EN.
- Defined: a 16-bit saturating counter increments on each grant taken while cpu_valid=1 (forced stall); it drives stat_forced.
- Undefined: the counter logic is absent and stat_forced is tied to 16'h0000.

Test Plan:
1. Reset held 3 cycles with host_req=1 -> grant_host=0, cpu_rdy=1, host_ack=0; after release with cpu_valid=0, grant in the first cycle and ack in the next.
2. CPU idle; host read of $7003 with cpu_state=8'hA5 -> grant at N, host_ack=1 at N+1 with host_rdata=8'hA5, held afterwards; host_req held high -> next grant at N+2.
3. CPU continuous valid reads, host_req high, HOST_MAX_WAIT=15 -> cpu_rdy low exactly 1 cycle after 15 refused cycles; cpu_rdata unchanged during the stall; stat_forced=1 when enabled.
4. HOST_MAX_WAIT=0, CPU continuous -> host write $0010=8'h5C granted immediately; CPU stalled 1 cycle, then runs; CPU read of $0010 returns 8'h5C.
5. CPU read of $0020 (=8'h11) at N, host read of $0021 (=8'h22) at N+1 (CPU idle) -> cpu_rdata=8'h11 from N+1 onward, host_rdata=8'h22 at N+2.
6. Reset asserted in the host grant cycle -> no host_ack; host_rdata=0; wait_cnt=0 after release.

Source files
------------

// File: rtl/monitor_bus_arbiter.sv
// monitor_bus_arbiter: shares the monitor bus between the CPU (default owner) and a host debug bridge.
// Define MONITOR_ARB_STATS_EN to count forced CPU stalls on stat_forced.
module monitor_bus_arbiter #(
  parameter int HOST_MAX_WAIT = 15,
  parameter int WAIT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic [15:0] cpu_address,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_rdata,
  input  logic        host_req,
  input  logic [15:0] host_address,
  input  logic        host_write,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [15:0] bus_address,
  output logic        bus_write,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        grant_host,
  output logic [15:0] stat_forced
);
  localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(HOST_MAX_WAIT);
  logic              host_ack_q;
  logic              cpu_pend;
  logic [WAIT_W-1:0] wait_cnt;
  logic [7:0]        cpu_rdata_q;
  logic [7:0]        host_rdata_q;
  assign grant_host  = ~reset & host_req & ~host_ack_q & (~cpu_valid | wait_cnt == MAX_W);
  assign cpu_rdy     = ~grant_host;
  assign bus_address = grant_host ? host_address : cpu_address;
  assign bus_wdata   = grant_host ? host_wdata : cpu_wdata;
  assign bus_write   = grant_host ? host_write : cpu_write & cpu_valid;
  assign host_ack    = host_ack_q;
  // Read data arrives one cycle after the address; each side latches only its own.
  assign cpu_rdata   = cpu_pend ? bus_rdata : cpu_rdata_q;
  assign host_rdata  = host_ack_q ? bus_rdata : host_rdata_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      host_ack_q   <= 1'b0;
      cpu_pend     <= 1'b0;
      wait_cnt     <= '0;
      cpu_rdata_q  <= 8'h00;
      host_rdata_q <= 8'h00;
    end else begin
      host_ack_q <= grant_host;
      cpu_pend   <= cpu_valid & ~grant_host;
      wait_cnt   <= (grant_host | ~host_req) ? '0 :
                    (cpu_valid & ~host_ack_q & wait_cnt != MAX_W) ? wait_cnt + WAIT_W'(1) : wait_cnt;
      if (cpu_pend) cpu_rdata_q <= bus_rdata;
      if (host_ack_q) host_rdata_q <= bus_rdata;
    end
`ifdef MONITOR_ARB_STATS_EN
  logic [15:0] stat_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) stat_q <= 16'h0000;
    else if (grant_host & cpu_valid & ~&stat_q) stat_q <= stat_q + 16'h0001;
  assign stat_forced = stat_q;
`else
  assign stat_forced = 16'h0000;
`endif
endmodule

// File: tb/tb_monitor_bus_arbiter.sv
// tb_monitor_bus_arbiter: vector table, directed corner sequences and random traffic against a transaction-level model.
module tb_monitor_bus_arbiter;
  localparam int MAXW = 15;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_valid = 1'b0, cpu_write = 1'b0, host_req = 1'b0, host_write = 1'b0;
  logic [15:0] cpu_address = 16'h0, host_address = 16'h0;
  logic [7:0] cpu_wdata = 8'h0, host_wdata = 8'h0;
  logic cpu_rdy, host_ack, bus_write, grant_host;
  logic [7:0] cpu_rdata, host_rdata, bus_wdata, bus_rdata;
  logic [15:0] bus_address, stat_forced;
  logic cpu_rdy0, host_ack0, bus_write0, grant_host0;
  logic [7:0] cpu_rdata0, host_rdata0, bus_wdata0, bus_rdata0;
  logic [15:0] bus_address0, stat_forced0;
  logic [7:0] mem [0:65535];
  logic [7:0] mem0 [0:65535];
  logic [7:0] m_mem [0:65535];
  int m_refused;
  logic m_ack, m_host_rd_valid;
  logic [7:0] m_cpu_data, m_host_data;
  logic [15:0] m_forced;
  logic obs_grant, obs_ack, g0, rdy0, ack0;
  logic [7:0] obs_cpu_rdata, obs_host_rdata, rd0;
  int errors = 0, checks = 0;

  typedef struct {
    logic cv, cw; logic [15:0] ca; logic [7:0] cd;
    logic hr, hw; logic [15:0] ha; logic [7:0] hd;
    logic g, a; logic [7:0] crd; logic hchk; logic [7:0] hrd;
  } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;

  monitor_bus_arbiter #(.HOST_MAX_WAIT(MAXW), .WAIT_W(4)) u (
    .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_address(cpu_address), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata), .host_req(host_req),
    .host_address(host_address), .host_write(host_write), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .bus_address(bus_address), .bus_write(bus_write), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .grant_host(grant_host), .stat_forced(stat_forced));

  monitor_bus_arbiter #(.HOST_MAX_WAIT(0), .WAIT_W(4)) u0 (
    .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_address(cpu_address), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_rdy(cpu_rdy0), .cpu_rdata(cpu_rdata0), .host_req(host_req),
    .host_address(host_address), .host_write(host_write), .host_wdata(host_wdata), .host_ack(host_ack0),
    .host_rdata(host_rdata0), .bus_address(bus_address0), .bus_write(bus_write0), .bus_wdata(bus_wdata0),
    .bus_rdata(bus_rdata0), .grant_host(grant_host0), .stat_forced(stat_forced0));

  // Bus decoder stand-ins: registered read, write takes effect at the edge.
  always @(posedge clk) begin
    bus_rdata <= mem[bus_address];
    if (bus_write) mem[bus_address] <= bus_wdata;
  end
  always @(posedge clk) begin
    bus_rdata0 <= mem0[bus_address0];
    if (bus_write0) mem0[bus_address0] <= bus_wdata0;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_stat(logic [15:0] n);
`ifdef MONITOR_ARB_STATS_EN
    return n;
`else
    return 16'h0000 & n;
`endif
  endfunction

  task automatic model_reset();
    m_refused = 0; m_ack = 1'b0; m_cpu_data = 8'h00; m_host_data = 8'h00;
    m_host_rd_valid = 1'b1; m_forced = 16'h0000;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1; cpu_valid = 1'b0; cpu_write = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_grant", grant_host, 1'b0);
      chk("rst_cpu_rdy", cpu_rdy, 1'b1);
      chk("rst_host_ack", host_ack, 1'b0);
      chk("rst_cpu_rdata", cpu_rdata, 8'h00);
      chk("rst_host_rdata", host_rdata, 8'h00);
      chk("rst_bus_write", bus_write, 1'b0);
      chk("rst_stat", stat_forced, 16'h0000);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One bus cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic eg;
    @(negedge clk);
    eg = host_req && !m_ack && (!cpu_valid || m_refused >= MAXW);
    obs_grant = grant_host; obs_ack = host_ack; obs_cpu_rdata = cpu_rdata; obs_host_rdata = host_rdata;
    g0 = grant_host0; rdy0 = cpu_rdy0; ack0 = host_ack0; rd0 = cpu_rdata0;
    chk("grant_host", grant_host, eg);
    chk("cpu_rdy", cpu_rdy, !eg);
    chk("host_ack", host_ack, m_ack);
    chk("cpu_rdata", cpu_rdata, m_cpu_data);
    if (m_host_rd_valid) chk("host_rdata", host_rdata, m_host_data);
    chk("bus_address", bus_address, eg ? host_address : cpu_address);
    chk("bus_write", bus_write, eg ? host_write : (cpu_valid & cpu_write));
    chk("stat_forced", stat_forced, exp_stat(m_forced));
    @(posedge clk);
    if (eg) begin
      if (host_write) begin m_host_rd_valid = 1'b0; m_mem[host_address] = host_wdata; end
      else begin m_host_data = m_mem[host_address]; m_host_rd_valid = 1'b1; end
      if (cpu_valid && m_forced != 16'hFFFF) m_forced = m_forced + 16'h1;
    end else if (cpu_valid) begin
      m_cpu_data = m_mem[cpu_address];
      if (cpu_write) m_mem[cpu_address] = cpu_wdata;
    end
    if (eg || !host_req) m_refused = 0;
    else if (cpu_valid && !m_ack) m_refused = (m_refused + 1 > MAXW) ? MAXW : m_refused + 1;
    m_ack = eg;
    #1;
  endtask

  // CPU reads every cycle while the host keeps asking: exactly one forced stall after MAXW refusals.
  task automatic busy_run(string tag);
    int first, stalls;
    logic [7:0] prev;
    first = -1; stalls = 0; prev = 8'h00;
    cpu_valid = 1'b1; cpu_write = 1'b0; host_req = 1'b1; host_write = 1'b0; host_address = 16'h0105;
    for (int i = 0; i < 17; i++) begin
      cpu_address = 16'h0100 | 16'($urandom_range(0, 15));
      step();
      if (obs_grant) begin stalls++; if (first < 0) first = i; end
      if (i == 16) chk({tag, "_stall_rdata_hold"}, obs_cpu_rdata, prev);
      prev = obs_cpu_rdata;
    end
    chk({tag, "_first_stall"}, first, MAXW);
    chk({tag, "_stall_count"}, stalls, 1);
    chk({tag, "_stat"}, stat_forced, exp_stat(16'h0001));
    host_req = 1'b0; cpu_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      mem[i] <= v; mem0[i] <= v; m_mem[i] = v;
    end
    mem[16'h7003] <= 8'hA5; m_mem[16'h7003] = 8'hA5;
    mem[16'h0020] <= 8'h11; m_mem[16'h0020] = 8'h11;
    mem[16'h0021] <= 8'h22; m_mem[16'h0021] = 8'h22;
    mem[16'h0040] <= 8'h33; m_mem[16'h0040] = 8'h33;
    model_reset();

    // cv cw ca cd | hr hw ha hd | grant ack cpu_rdata hchk host_rdata
    tbl[0]  = '{1'b1,1'b0,16'h0020,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,8'h00,1'b1,8'h00};
    tbl[1]  = '{1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,16'h0021,8'h00, 1'b1,1'b0,8'h11,1'b1,8'h00};
    tbl[2]  = '{1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b1,8'h11,1'b1,8'h22};
    tbl[3]  = '{1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,8'h11,1'b1,8'h22};
    tbl[4]  = '{1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,16'h7003,8'h00, 1'b1,1'b0,8'h11,1'b1,8'h22};
    tbl[5]  = '{1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,16'h7003,8'h00, 1'b0,1'b1,8'h11,1'b1,8'hA5};
    tbl[6]  = '{1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,16'h7003,8'h00, 1'b1,1'b0,8'h11,1'b1,8'hA5};
    tbl[7]  = '{1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b1,8'h11,1'b1,8'hA5};
    tbl[8]  = '{1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,8'h11,1'b1,8'hA5};
    tbl[9]  = '{1'b1,1'b1,16'h0040,8'h77, 1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,8'h11,1'b1,8'hA5};
    tbl[10] = '{1'b1,1'b0,16'h0040,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,8'h33,1'b1,8'hA5};
    tbl[11] = '{1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,8'h77,1'b1,8'hA5};

    // Reset held with a pending host request, then immediate grant and ack.
    host_req = 1'b1; host_address = 16'h7003;
    do_reset(3);
    step(); chk("t1_grant_first", obs_grant, 1'b1);
    step(); chk("t1_ack_next", obs_ack, 1'b1);
    host_req = 1'b0;

    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      cpu_valid = tbl[i].cv; cpu_write = tbl[i].cw; cpu_address = tbl[i].ca; cpu_wdata = tbl[i].cd;
      host_req = tbl[i].hr; host_write = tbl[i].hw; host_address = tbl[i].ha; host_wdata = tbl[i].hd;
      step();
      chk($sformatf("tbl%0d_grant", i), obs_grant, tbl[i].g);
      chk($sformatf("tbl%0d_ack", i), obs_ack, tbl[i].a);
      chk($sformatf("tbl%0d_cpu_rdata", i), obs_cpu_rdata, tbl[i].crd);
      if (tbl[i].hchk) chk($sformatf("tbl%0d_host_rdata", i), obs_host_rdata, tbl[i].hrd);
    end
    cpu_valid = 1'b0; host_req = 1'b0;

    do_reset(1);
    busy_run("t3");

    // Reset lands in the forced-grant cycle: ack dropped, data cleared, wait count restarts.
    do_reset(1);
    cpu_valid = 1'b1; cpu_write = 1'b0; host_req = 1'b1; host_write = 1'b0; host_address = 16'h0105;
    for (int i = 0; i < MAXW; i++) begin
      cpu_address = 16'h0100 | 16'($urandom_range(0, 15));
      step();
    end
    @(negedge clk);
    chk("t6_pre_grant", grant_host, 1'b1);
    reset = 1'b1;
    #1 chk("t6_grant_drop", grant_host, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_no_ack", host_ack, 1'b0);
    chk("t6_host_rdata", host_rdata, 8'h00);
    chk("t6_cpu_rdata", cpu_rdata, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    busy_run("t6");

    // Zero-wait instance: host write wins at once, CPU stalls one cycle, then reads it back.
    do_reset(1);
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0030;
    host_req = 1'b1; host_write = 1'b1; host_address = 16'h0010; host_wdata = 8'h5C;
    step();
    chk("t4_grant0", g0, 1'b1);
    chk("t4_stall0", rdy0, 1'b0);
    host_req = 1'b0; host_write = 1'b0;
    step();
    chk("t4_ack0", ack0, 1'b1);
    chk("t4_run0", rdy0, 1'b1);
    cpu_address = 16'h0010;
    step();
    chk("t4_rdy0", rdy0, 1'b1);
    cpu_valid = 1'b0;
    step();
    chk("t4_rdata0", rd0, 8'h5C);
    chk("t4_stat0", stat_forced0, exp_stat(16'h0001));

    // Random traffic; blocks alternate between a busy and a lightly loaded CPU.
    for (int i = 0; i < 3000; i++) begin
      int busy;
      busy = ((i / 200) % 2 == 1) ? 97 : 60;
      if (i == 1500) do_reset(2);
      if ($urandom_range(0, 7) == 0) host_req = ~host_req;
      if ($urandom_range(0, 3) == 0) begin
        host_write = ($urandom_range(0, 3) == 0);
        host_address = 16'h0100 | 16'($urandom_range(0, 15));
        host_wdata = 8'($urandom);
      end
      cpu_valid = ($urandom_range(0, 99) < busy);
      cpu_write = ($urandom_range(0, 9) < 3);
      cpu_address = 16'h0100 | 16'($urandom_range(0, 15));
      cpu_wdata = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
